// File: rtl/gaussian_tap_fetcher_if.sv
// Frame-memory read port plus window valid/ready channel of the Gaussian tap fetcher.
// master = fetcher side, slave = memory/downstream side.
interface gaussian_tap_fetcher_if #(
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 24
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [PIX_W-1:0]   mem_q;
    logic               win_valid;
    logic               win_ready;
    logic [9*PIX_W-1:0] win_data;
    logic [ADDR_W-1:0]  win_addr;

    modport master (
        output mem_addr, mem_rd, win_valid, win_data, win_addr,
        input  mem_q, win_ready
    );

    modport slave (
        input  mem_addr, mem_rd, win_valid, win_data, win_addr,
        output mem_q, win_ready
    );
endinterface

// File: rtl/gaussian_tap_fetcher.sv
// Walks a column-major frame pixel by pixel, reads each clamped 3x3 neighbourhood
// from frame memory and presents it as one window on a valid/ready channel.
module gaussian_tap_fetcher #(
    parameter int COLS    = 160,
    parameter int ROWS    = 120,
    parameter int ADDR_W  = 15,
    parameter int PIX_W   = 24,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    gaussian_tap_fetcher_if.master bus
);
    localparam int CX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CY_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CX_W-1:0] X_LAST = CX_W'(COLS - 1);
    localparam logic [CY_W-1:0] Y_LAST = CY_W'(ROWS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CX_W-1:0]    cx_q, cx_d;
    logic [CY_W-1:0]    cy_q, cy_d;
    logic [3:0]         k_q, k_d;
    logic [MEM_LAT-1:0] pvld_q, pvld_d;
    logic [3:0]         pidx_q [MEM_LAT];
    logic [3:0]         pidx_d [MEM_LAT];
    logic [PIX_W-1:0]   slot_q [9];
    logic [PIX_W-1:0]   slot_d [9];

    logic [1:0]      xs, ys;
    logic [CX_W-1:0] tx;
    logic [CY_W-1:0] ty;
    logic            issue;
    logic            last_pix;
    logic            tap8_back;

    assign issue     = (state_q == S_ISSUE);
    assign last_pix  = (cx_q == X_LAST) && (cy_q == Y_LAST);
    assign tap8_back = pvld_q[MEM_LAT-1] && (pidx_q[MEM_LAT-1] == 4'd8);

    // Tap k = (dx+1)*3 + (dy+1); the column/row selectors are 0..2 for offsets -1..+1.
    always_comb begin
        case (k_q)
            4'd0, 4'd1, 4'd2: xs = 2'd0;
            4'd3, 4'd4, 4'd5: xs = 2'd1;
            default:          xs = 2'd2;
        endcase
        case (k_q)
            4'd0, 4'd3, 4'd6: ys = 2'd0;
            4'd1, 4'd4, 4'd7: ys = 2'd1;
            default:          ys = 2'd2;
        endcase
        case (xs)
            2'd0:    tx = (cx_q == '0) ? '0 : cx_q - 1'b1;
            2'd1:    tx = cx_q;
            default: tx = (cx_q == X_LAST) ? cx_q : cx_q + 1'b1;
        endcase
        case (ys)
            2'd0:    ty = (cy_q == '0) ? '0 : cy_q - 1'b1;
            2'd1:    ty = cy_q;
            default: ty = (cy_q == Y_LAST) ? cy_q : cy_q + 1'b1;
        endcase
    end

    assign bus.mem_rd    = issue;
    assign bus.win_valid = (state_q == S_HOLD);
    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_HOLD);
    assign done          = (state_q == S_DONE);
    assign bus.mem_addr  = issue ? ADDR_W'(32'(tx) * 32'(ROWS) + 32'(ty)) : '0;
    assign bus.win_addr  = ADDR_W'(32'(cx_q) * 32'(ROWS) + 32'(cy_q));

    for (genvar g = 0; g < 9; g++) begin : g_win
        assign bus.win_data[g*PIX_W +: PIX_W] = slot_q[g];
    end

    // Each issued tap index rides alongside its read so returning data lands in the right slot.
    always_comb begin
        pvld_d[0] = issue;
        pidx_d[0] = k_q;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            pvld_d[i] = pvld_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end
        slot_d = slot_q;
        if (pvld_q[MEM_LAT-1]) begin
            slot_d[pidx_q[MEM_LAT-1]] = bus.mem_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            S_ISSUE: begin
                if (k_q == 4'd8) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (tap8_back) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.win_ready) begin
                    if (last_pix) begin
                        state_d = S_DONE;
                        cx_d    = '0;
                        cy_d    = '0;
                    end else begin
                        state_d = S_ISSUE;
                        if (cy_q == Y_LAST) begin
                            cy_d = '0;
                            cx_d = cx_q + 1'b1;
                        end else begin
                            cy_d = cy_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cx_d    = '0;
                cy_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            k_q     <= '0;
            pvld_q  <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                pidx_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 9; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
            pvld_q  <= pvld_d;
            pidx_q  <= pidx_d;
            slot_q  <= slot_d;
        end
    end
endmodule

// File: tb/tb_gaussian_tap_fetcher.sv
// Directed bench: a full-size fetcher for first/interior windows, backpressure and abort,
// and a 4x3 fetcher for the corner window, done pulse and whole-pass timing.
module tb_gaussian_tap_fetcher;
    localparam int ADDR_W = 15;
    localparam int PIX_W  = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic b_rst, b_start, b_busy, b_done;
    logic s_rst, s_start, s_busy, s_done;

    gaussian_tap_fetcher_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) b_bus ();
    gaussian_tap_fetcher_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) s_bus ();

    gaussian_tap_fetcher #(.COLS(160), .ROWS(120), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .MEM_LAT(1)) u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done), .bus(b_bus)
    );

    gaussian_tap_fetcher #(.COLS(4), .ROWS(3), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .MEM_LAT(1)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done), .bus(s_bus)
    );

    // Frame memory returns its own address one cycle later.
    always @(posedge clk) b_bus.mem_q <= PIX_W'(b_bus.mem_addr);
    always @(posedge clk) s_bus.mem_q <= PIX_W'(s_bus.mem_addr);

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_window(input string tag, input logic [9*PIX_W-1:0] d,
                                input logic [ADDR_W-1:0] addr, input int exp_addr, input int e [9]);
        logic [PIX_W-1:0] t;
        check($sformatf("%s_addr", tag), 32'(addr), exp_addr);
        for (int k = 0; k < 9; k++) begin
            t = d[k*PIX_W +: PIX_W];
            check($sformatf("%s_k%0d", tag, k), 32'(t), e[k]);
        end
    endtask

    task automatic check_big_reset(input string tag);
        check({tag, "_busy"}, 32'(b_busy), 0);
        check({tag, "_done"}, 32'(b_done), 0);
        check({tag, "_rd"}, 32'(b_bus.mem_rd), 0);
        check({tag, "_valid"}, 32'(b_bus.win_valid), 0);
        check({tag, "_maddr"}, 32'(b_bus.mem_addr), 0);
        check({tag, "_waddr"}, 32'(b_bus.win_addr), 0);
        check({tag, "_wdata"}, 32'(|b_bus.win_data), 0);
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        while (!b_bus.win_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_to(input int from, input int target);
        int idx = from;
        int cyc = 0;
        while (!(b_bus.win_valid && idx == target) && cyc < 20000) begin
            if (b_bus.win_valid) begin
                b_bus.win_ready = 1'b1;
                idx++;
            end else begin
                b_bus.win_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        b_bus.win_ready = 1'b0;
        check($sformatf("run_to_%0d_bound", target), 32'(cyc < 20000), 1);
        check($sformatf("run_to_%0d_addr", target), 32'(b_bus.win_addr), target);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e [9];
        logic [9*PIX_W-1:0] held;
        int first_rd, done_at, done_cnt, xfers;
        bit corner_seen;

        b_rst = 1'b0; s_rst = 1'b0; b_start = 1'b0; s_start = 1'b0;
        b_bus.win_ready = 1'b0; s_bus.win_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_big_reset("rst");
        b_rst = 1'b1; s_rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(b_busy), 0);
        check("idle_maddr", 32'(b_bus.mem_addr), 0);

        // T1: first window, issue order and exact valid timing.
        e = '{0, 0, 1, 0, 0, 1, 120, 120, 121};
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check("t1_busy", 32'(b_busy), 1);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("t1_rd%0d", k), 32'(b_bus.mem_rd), 1);
            check($sformatf("t1_maddr%0d", k), 32'(b_bus.mem_addr), e[k]);
            @(negedge clk);
        end
        check("t1_drain_rd", 32'(b_bus.mem_rd), 0);
        check("t1_drain_valid", 32'(b_bus.win_valid), 0);
        @(negedge clk);
        check("t1_valid_t10", 32'(b_bus.win_valid), 1);
        check_window("t1", b_bus.win_data, b_bus.win_addr, 0, e);

        // T4: backpressure holds the window and stalls the walk.
        held = b_bus.win_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_valid%0d", i), 32'(b_bus.win_valid), 1);
            check($sformatf("t4_rd%0d", i), 32'(b_bus.mem_rd), 0);
            check($sformatf("t4_waddr%0d", i), 32'(b_bus.win_addr), 0);
            check($sformatf("t4_data%0d", i), 32'(b_bus.win_data == held), 1);
        end
        b_bus.win_ready = 1'b1;
        @(negedge clk);
        b_bus.win_ready = 1'b0;
        check("t4_after_valid", 32'(b_bus.win_valid), 0);
        check("t4_after_rd", 32'(b_bus.mem_rd), 1);
        wait_valid("t4");
        e = '{0, 1, 2, 0, 1, 2, 120, 121, 122};
        check_window("t4_next", b_bus.win_data, b_bus.win_addr, 1, e);

        // T6: start while busy has no effect on the sequence.
        b_bus.win_ready = 1'b1;
        @(negedge clk);
        b_bus.win_ready = 1'b0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_valid("t6");
        e = '{1, 2, 3, 1, 2, 3, 121, 122, 123};
        check_window("t6", b_bus.win_data, b_bus.win_addr, 2, e);
        check("t6_busy", 32'(b_busy), 1);

        // T5: abort during ISSUE of window 50, then restart from pixel (0,0).
        run_to(2, 49);
        b_bus.win_ready = 1'b1;
        @(negedge clk);
        b_bus.win_ready = 1'b0;
        check("t5_issue_rd", 32'(b_bus.mem_rd), 1);
        check("t5_issue_waddr", 32'(b_bus.win_addr), 50);
        @(negedge clk);
        b_rst = 1'b0;
        #1;
        check_big_reset("t5_abort");
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_valid("t5_restart");
        e = '{0, 0, 1, 0, 0, 1, 120, 120, 121};
        check_window("t5_first", b_bus.win_data, b_bus.win_addr, 0, e);

        // T2: interior pixel (5,7).
        run_to(0, 607);
        e = '{486, 487, 488, 606, 607, 608, 726, 727, 728};
        check_window("t2", b_bus.win_data, b_bus.win_addr, 607, e);

        // T3 + full pass on a 4x3 frame, ready held high throughout.
        e = '{7, 8, 8, 10, 11, 11, 10, 11, 11};
        s_bus.win_ready = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        first_rd = -1; done_at = -1; done_cnt = 0; xfers = 0; corner_seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (s_bus.mem_rd && first_rd < 0) first_rd = c;
            if (s_bus.win_valid) begin
                if (xfers == 11 && !corner_seen) begin
                    corner_seen = 1'b1;
                    check_window("t3_corner", s_bus.win_data, s_bus.win_addr, 11, e);
                end
                xfers++;
            end
            if (s_done) begin
                done_cnt++;
                done_at = c;
                check("t3_done_busy", 32'(s_busy), 0);
            end
            @(negedge clk);
        end
        check("t3_corner_seen", 32'(corner_seen), 1);
        check("t3_xfers", 32'(xfers), 12);
        check("t3_done_cnt", 32'(done_cnt), 1);
        check("t3_pass_cycles", 32'(done_at - first_rd), 132);
        check("t3_end_busy", 32'(s_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
